// File: rtl/decode_nlane.sv
// N-lane decode / operand-fetch stage.
// Splits an issue bundle into lanes (lane 0 in the MSB word), reads GPR operands,
// applies the lane-kill rule for Liw and control ops, and registers the result behind
// a valid/ready handshake. A per-register load-use scoreboard throttles in_ready.
module decode_nlane #(
    parameter int LANES    = 2,
    parameter int XLEN     = 32,
    parameter int NREG     = 32,
    parameter int LOAD_LAT = 2
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [32*LANES-1:0]    inst,
    input  logic [NREG*XLEN-1:0]   gpr_flat,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [32*LANES-1:0]    out_inst,
    output logic [XLEN*LANES-1:0]  srca,
    output logic [XLEN*LANES-1:0]  srcb,
    output logic [XLEN*LANES-1:0]  srcs,
    output logic [4*LANES-1:0]     e_type,
    output logic [5*LANES-1:0]     rt,
    output logic [LANES-1:0]       rt_flag,
    output logic [32*LANES-1:0]    addr,
    output logic [4*LANES-1:0]     wea
);

    localparam int          CW       = (LOAD_LAT < 1) ? 1 : $clog2(LOAD_LAT + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(LOAD_LAT);
    localparam logic [31:0] NOP      = 32'hE000_0000;

    localparam logic [5:0] OP_ADDI  = 6'h00;
    localparam logic [5:0] OP_SUBI  = 6'h01;
    localparam logic [5:0] OP_ADD   = 6'h02;
    localparam logic [5:0] OP_SUB   = 6'h03;
    localparam logic [5:0] OP_SRAWI = 6'h04;
    localparam logic [5:0] OP_SLAWI = 6'h05;
    localparam logic [5:0] OP_LOAD  = 6'h10;
    localparam logic [5:0] OP_STORE = 6'h11;
    localparam logic [5:0] OP_LI    = 6'h12;
    localparam logic [5:0] OP_LIW   = 6'h13;
    localparam logic [5:0] OP_JUMP  = 6'h18;
    localparam logic [5:0] OP_BL    = 6'h1A;
    localparam logic [5:0] OP_BLRR  = 6'h1B;
    localparam logic [5:0] OP_BEQ   = 6'h20;
    localparam logic [5:0] OP_BLE   = 6'h21;
    localparam logic [5:0] OP_BLT   = 6'h22;
    localparam logic [5:0] OP_CMPD  = 6'h23;
    localparam logic [5:0] OP_CMPF  = 6'h24;

    // Register-register forms take operand B from gpr[rb].
    function automatic logic is_xform(input logic [5:0] op);
        return op inside {OP_ADD, OP_SUB, [6'h08:6'h0B], OP_CMPD, OP_CMPF};
    endfunction

    // Liw and every control op end the useful part of the bundle.
    function automatic logic is_kill(input logic [5:0] op);
        return op inside {OP_LIW, [OP_JUMP:OP_BLRR], [OP_BEQ:OP_BLT]};
    endfunction

    // Branch targets carry a 26-bit unsigned displacement in operand B.
    function automatic logic is_li_form(input logic [5:0] op);
        return op inside {OP_JUMP, OP_BL, OP_BEQ, OP_BLE, OP_BLT};
    endfunction

    // Ops that write a GPR directly from the execute stage (Load is enabled later at Mem2).
    function automatic logic wb_en(input logic [5:0] op);
        return op inside {[OP_ADDI:OP_SLAWI], OP_LI, OP_LIW, OP_BL, OP_BLRR, [6'h28:6'h2B]};
    endfunction

    function automatic logic [3:0] exec_type(input logic [5:0] op);
        case (op)
            OP_ADDI, OP_ADD: return 4'd1;
            OP_SUBI, OP_SUB: return 4'd2;
            OP_SRAWI:        return 4'd3;
            OP_SLAWI:        return 4'd4;
            default:         return 4'd0;
        endcase
    endfunction

    function automatic logic signed [XLEN-1:0] sext16(input logic [15:0] v);
        return XLEN'($signed(v));
    endfunction

    function automatic logic signed [XLEN-1:0] zext26(input logic [25:0] v);
        return $signed(XLEN'(v));
    endfunction

    // Output and scoreboard state.
    logic                   out_valid_q;
    logic [32*LANES-1:0]    out_inst_q, out_inst_d;
    logic [XLEN*LANES-1:0]  srca_q, srca_d, srcb_q, srcb_d, srcs_q, srcs_d;
    logic [4*LANES-1:0]     e_type_q, e_type_d;
    logic [5*LANES-1:0]     rt_q, rt_d;
    logic [LANES-1:0]       rt_flag_q, rt_flag_d;
    logic [32*LANES-1:0]    addr_q, addr_d;
    logic [4*LANES-1:0]     wea_q, wea_d;
    logic [CW-1:0]          cnt_q [NREG];

    // Decode scratch.
    logic [31:0]             lane_w [LANES];
    logic                    kill_run, killed_l;
    logic [31:0]             w_l, nxt_l;
    logic [5:0]              op_l;
    logic [4:0]              f_rt, f_ra, f_rb;
    logic [15:0]             si_l;
    logic [25:0]             li_l;
    logic signed [XLEN-1:0]  a_val, b_val, s_val;
    logic signed [31:0]      addr_l;
    int                      nk;
    logic                    hazard, accept;
    logic [NREG-1:0]         ld_set;

    // Per-lane decode, kill propagation, hazard detection and load-set collection.
    always_comb begin
        out_inst_d = '0;
        srca_d     = '0;
        srcb_d     = '0;
        srcs_d     = '0;
        e_type_d   = '0;
        rt_d       = '0;
        rt_flag_d  = '0;
        addr_d     = '0;
        wea_d      = '0;
        hazard     = 1'b0;
        ld_set     = '0;
        kill_run   = 1'b0;
        killed_l   = 1'b0;
        w_l        = NOP;
        nxt_l      = '0;
        op_l       = '0;
        f_rt       = '0;
        f_ra       = '0;
        f_rb       = '0;
        si_l       = '0;
        li_l       = '0;
        a_val      = '0;
        b_val      = '0;
        s_val      = '0;
        addr_l     = '0;
        nk         = 0;
        for (int k = 0; k < LANES; k++) begin
            lane_w[k] = inst[32*(LANES-k)-1 -: 32];
        end
        for (int k = 0; k < LANES; k++) begin
            // A killed lane is decoded as a NOP so it carries no side effects.
            killed_l = kill_run;
            w_l      = killed_l ? NOP : lane_w[k];
            op_l     = w_l[31:26];
            f_rt     = w_l[25:21];
            f_ra     = w_l[20:16];
            f_rb     = w_l[15:11];
            si_l     = w_l[15:0];
            li_l     = w_l[25:0];
            nk       = (k < LANES - 1) ? k + 1 : k;
            nxt_l    = (k < LANES - 1) ? lane_w[nk] : 32'h0;

            a_val = $signed(gpr_flat[int'(f_ra)*XLEN +: XLEN]);
            s_val = $signed(gpr_flat[int'(f_rt)*XLEN +: XLEN]);
            if (is_xform(op_l))
                b_val = $signed(gpr_flat[int'(f_rb)*XLEN +: XLEN]);
            else if (op_l == OP_LIW)
                b_val = $signed(XLEN'(nxt_l));
            else if (is_li_form(op_l))
                b_val = zext26(li_l);
            else
                b_val = sext16(si_l);
            addr_l = $signed(a_val[31:0]) + 32'(sext16(si_l));

            out_inst_d[32*(LANES-k)-1 -: 32]  = w_l;
            srca_d[XLEN*(LANES-k)-1 -: XLEN]  = a_val;
            srcb_d[XLEN*(LANES-k)-1 -: XLEN]  = b_val;
            srcs_d[XLEN*(LANES-k)-1 -: XLEN]  = s_val;
            e_type_d[4*(LANES-k)-1 -: 4]      = exec_type(op_l);
            rt_d[5*(LANES-k)-1 -: 5]          = (op_l == OP_BL || op_l == OP_BLRR) ? 5'd31 : f_rt;
            rt_flag_d[LANES-1-k]              = wb_en(op_l);
            addr_d[32*(LANES-k)-1 -: 32]      = addr_l;
            wea_d[4*(LANES-k)-1 -: 4]         = (op_l == OP_STORE) ? 4'hF : 4'h0;

            if (!killed_l) begin
                if (cnt_q[f_ra] != '0)
                    hazard = 1'b1;
                if (is_xform(op_l) && cnt_q[f_rb] != '0)
                    hazard = 1'b1;
                if (op_l == OP_STORE && cnt_q[f_rt] != '0)
                    hazard = 1'b1;
                if (op_l == OP_LOAD)
                    ld_set[f_rt] = 1'b1;
            end
            kill_run = kill_run | is_kill(op_l);
        end
    end

    assign in_ready = rstn & (~out_valid_q | out_ready) & ~hazard & ~flush;
    assign accept   = in_valid & in_ready;

    // Control outputs: reset, flush squash, bundle load, drain to bubble, or hold.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            out_valid_q <= 1'b0;
            out_inst_q  <= {LANES{NOP}};
            rt_flag_q   <= '0;
            wea_q       <= '0;
            e_type_q    <= '0;
        end else if (flush) begin
            out_valid_q <= 1'b0;
            out_inst_q  <= {LANES{NOP}};
            rt_flag_q   <= '0;
            wea_q       <= '0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            out_inst_q  <= out_inst_d;
            rt_flag_q   <= rt_flag_d;
            wea_q       <= wea_d;
            e_type_q    <= e_type_d;
        end else if (out_ready || !out_valid_q) begin
            out_valid_q <= 1'b0;
            rt_flag_q   <= '0;
            wea_q       <= '0;
        end
    end

    // Operand data loads only on accept; its value is meaningless while out_valid is low.
    always_ff @(posedge clk) begin
        if (accept) begin
            srca_q <= srca_d;
            srcb_q <= srcb_d;
            srcs_q <= srcs_d;
            rt_q   <= rt_d;
            addr_q <= addr_d;
        end
    end

    // Load-use scoreboard: a new load wins over the countdown; flush leaves it intact.
    always_ff @(posedge clk) begin
        for (int r = 0; r < NREG; r++) begin
            if (!rstn)
                cnt_q[r] <= '0;
            else if (accept && ld_set[r])
                cnt_q[r] <= CNT_INIT;
            else if (out_ready && cnt_q[r] != '0)
                cnt_q[r] <= cnt_q[r] - CW'(1);
        end
    end

    assign out_valid = out_valid_q;
    assign out_inst  = out_inst_q;
    assign srca      = srca_q;
    assign srcb      = srcb_q;
    assign srcs      = srcs_q;
    assign e_type    = e_type_q;
    assign rt        = rt_q;
    assign rt_flag   = rt_flag_q;
    assign addr      = addr_q;
    assign wea       = wea_q;

endmodule
